// File: rtl/prog_rom_banked_pkg.sv
// Shared types and default sizing for the banked program ROM.
package prog_rom_banked_pkg;

  localparam int N_CORES    = 4;
  localparam int BANKS      = 2;
  localparam int ROM_DEPTH  = 1024;
  localparam int WORD_W_DEF = 32;

  typedef logic [WORD_W_DEF-1:0]       ir_word_t;
  typedef logic [$clog2(ROM_DEPTH)-1:0] rom_addr_t;
  typedef logic [$clog2(BANKS)-1:0]     bank_idx_t;

  // Host write handshake states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/prog_rom_banked_rr_arbiter.sv
// One-hot round-robin arbiter; priority starts just after the last granted requester.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_found;

  // Scan requesters starting one past the last winner
  always_comb begin
    int unsigned idx;
    o_gnt      = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        w_next_ptr = PW'(idx);
        w_found    = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Remember the last winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_next_ptr;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/prog_rom_banked.sv
// Banked shared instruction ROM: host programming link plus N_CORES arbitrated fetch ports.
// Optional macro PROG_ROM_PARITY_EN adds a stored even-parity bit and a per-core par_err output.
module prog_rom_banked #(
  parameter int N_CORES = prog_rom_banked_pkg::N_CORES,
  parameter int N_BANKS = prog_rom_banked_pkg::BANKS,
  parameter int DEPTH   = prog_rom_banked_pkg::ROM_DEPTH,
  parameter int WORD_W  = prog_rom_banked_pkg::WORD_W_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     prog,
  input  logic                                     p_avail,
  input  logic [WORD_W-1:0]                        p_d_in,
  output logic                                     p_ready,
  output logic                                     p_lo_ack,
  output logic                                     p_full,
  output logic [$clog2(DEPTH):0]                   p_count,
  output logic                                     core_rst,
  input  logic [N_CORES-1:0]                       active,
  input  logic [N_CORES-1:0][$clog2(DEPTH)-1:0]    addr,
  output logic [N_CORES-1:0][WORD_W-1:0]           d_out,
  output logic [N_CORES-1:0]                       ready
`ifdef PROG_ROM_PARITY_EN
  ,
  output logic [N_CORES-1:0]                       par_err
`endif
);

  import prog_rom_banked_pkg::*;

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int BW   = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int ROWS = DEPTH / N_BANKS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef PROG_ROM_PARITY_EN
  localparam int MW   = WORD_W + 1;

  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction
`else
  localparam int MW   = WORD_W;
`endif

  logic [1:0]                       r_state;
  logic                             r_p_ready;
  logic                             r_p_lo_ack;
  logic                             r_p_full;
  logic [CW-1:0]                    r_count;
  logic [WORD_W-1:0]                r_wdata;
  logic                             r_prog_ff;
  logic                             r_rst_q;
  logic [N_CORES-1:0]               r_ready;
  logic [N_CORES-1:0][WORD_W-1:0]   r_d_out;

  logic                             w_prog_rise;
  logic                             w_core_rst;
  logic                             w_wr_en;
  logic [BW-1:0]                    w_wr_bank;
  logic [RW-1:0]                    w_wr_row;
  logic [MW-1:0]                    w_wr_word;
  logic [N_CORES-1:0]               w_req;
  logic [N_CORES-1:0]               w_gnt_any;
  logic [BW-1:0]                    w_bank_of [N_CORES];
  logic [RW-1:0]                    w_row_of  [N_CORES];
  logic [N_CORES-1:0]               w_gnt_bank [N_BANKS];
  logic [MW-1:0]                    w_bank_rd  [N_BANKS];

  assign w_prog_rise = prog & ~r_prog_ff;
  assign w_core_rst  = ~rst_n | r_rst_q | prog | r_prog_ff;
  // The word latched in ACCEPT lands in memory on the first COMMIT cycle, marked by the ack pulse
  assign w_wr_en     = rst_n & (r_state == ST_COMMIT) & r_p_lo_ack;
  assign w_wr_bank   = BW'(int'(r_count) % N_BANKS);
  assign w_wr_row    = RW'(int'(r_count) / N_BANKS);
`ifdef PROG_ROM_PARITY_EN
  assign w_wr_word   = {even_parity(r_wdata), r_wdata};
`else
  assign w_wr_word   = r_wdata;
`endif

  // Programming-mode edge tracking and post-reset hold of core_rst
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prog_ff <= 1'b0;
      r_rst_q   <= 1'b1;
    end else begin
      r_prog_ff <= prog;
      r_rst_q   <= 1'b0;
    end
  end

  // Host write handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_p_ready  <= 1'b0;
      r_p_lo_ack <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_p_ready  <= 1'b0;
      r_p_lo_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (prog && p_avail && !r_p_full) begin
            r_state   <= ST_ACCEPT;
            r_p_ready <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCEPT: begin
          r_wdata    <= p_d_in;
          r_p_lo_ack <= 1'b1;
          r_state    <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_state <= p_avail ? ST_COMMIT : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Session write pointer, count and full flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_p_full <= 1'b0;
    end else if (w_prog_rise) begin
      r_count  <= '0;
      r_p_full <= 1'b0;
    end else if (w_wr_en) begin
      r_count  <= r_count + 1'b1;
      r_p_full <= (r_count == CW'(DEPTH - 1));
    end else begin
      r_count  <= r_count;
      r_p_full <= r_p_full;
    end
  end

  // A core that is receiving data this cycle sits out one arbitration round
  always_comb begin
    w_req     = active & ~r_ready & {N_CORES{~w_core_rst}};
    w_gnt_any = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_bank_of[i] = BW'(int'(addr[i]) % N_BANKS);
      w_row_of[i]  = RW'(int'(addr[i]) / N_BANKS);
    end
    for (int b = 0; b < N_BANKS; b++) begin
      w_gnt_any = w_gnt_any | w_gnt_bank[b];
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [MW-1:0]      r_mem [ROWS];
    logic [N_CORES-1:0] w_req_b;
    logic [N_CORES-1:0] w_gnt_b;
    logic [RW-1:0]      w_row;

    // Requests targeting this bank and the winner's row
    always_comb begin
      w_req_b = '0;
      w_row   = '0;
      for (int i = 0; i < N_CORES; i++) begin
        w_req_b[i] = w_req[i] && (w_bank_of[i] == BW'(b));
        if (w_gnt_b[i]) begin
          w_row = w_row_of[i];
        end else begin
          w_row = w_row;
        end
      end
    end

    rr_arbiter #(.N(N_CORES)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_req_b),
      .o_gnt (w_gnt_b)
    );

    // Memory is deliberately left out of reset
    always_ff @(posedge clk) begin
      if (w_wr_en && (w_wr_bank == BW'(b))) begin
        r_mem[w_wr_row] <= w_wr_word;
      end
    end

    assign w_bank_rd[b]  = r_mem[w_row];
    assign w_gnt_bank[b] = w_gnt_b;
  end

`ifdef PROG_ROM_PARITY_EN
  logic [N_CORES-1:0] r_par_err;
`endif

  // Capture granted read data and pulse ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready <= '0;
      r_d_out <= '0;
`ifdef PROG_ROM_PARITY_EN
      r_par_err <= '0;
`endif
    end else begin
      r_ready <= w_gnt_any;
      for (int i = 0; i < N_CORES; i++) begin
        if (w_gnt_any[i]) begin
          r_d_out[i] <= w_bank_rd[w_bank_of[i]][WORD_W-1:0];
`ifdef PROG_ROM_PARITY_EN
          r_par_err[i] <= w_bank_rd[w_bank_of[i]][WORD_W]
                          ^ even_parity(w_bank_rd[w_bank_of[i]][WORD_W-1:0]);
`endif
        end else begin
          r_d_out[i] <= r_d_out[i];
        end
      end
    end
  end

  assign p_ready  = r_p_ready;
  assign p_lo_ack = r_p_lo_ack;
  assign p_full   = r_p_full;
  assign p_count  = r_count;
  assign core_rst = w_core_rst;
  assign d_out    = r_d_out;
  assign ready    = r_ready;
`ifdef PROG_ROM_PARITY_EN
  assign par_err  = r_par_err;
`endif

endmodule

// File: tb/tb_prog_rom_banked.sv
// Directed self-checking bench for prog_rom_banked (default build, 4 cores, 2 banks, 1024 words).
module tb_prog_rom_banked;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              prog;
  logic              p_avail;
  logic [31:0]       p_d_in;
  logic              p_ready;
  logic              p_lo_ack;
  logic              p_full;
  logic [10:0]       p_count;
  logic              core_rst;
  logic [3:0]        active;
  logic [3:0][9:0]   addr;
  logic [3:0][31:0]  d_out;
  logic [3:0]        ready;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [31:0] W0 = 32'hDEAD_BEEF;
  localparam logic [31:0] W1 = 32'h1234_5678;
  localparam logic [31:0] W2 = 32'hA5A5_0F0F;

  prog_rom_banked dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .prog     (prog),
    .p_avail  (p_avail),
    .p_d_in   (p_d_in),
    .p_ready  (p_ready),
    .p_lo_ack (p_lo_ack),
    .p_full   (p_full),
    .p_count  (p_count),
    .core_rst (core_rst),
    .active   (active),
    .addr     (addr),
    .d_out    (d_out),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host word: fresh p_avail, expect one p_ready then one p_lo_ack
  task automatic write_word(input logic [31:0] w, input logic [10:0] exp_cnt);
    bit got;
    got = 1'b0;
    p_d_in  = w;
    p_avail = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      tick();
      if (p_ready) got = 1'b1;
    end
    chk("wr_p_ready_seen", 64'(got), 64'd1);
    p_avail = 1'b0;
    tick();
    chk("wr_lo_ack", 64'(p_lo_ack), 64'd1);
    chk("wr_ready_once", 64'(p_ready), 64'd0);
    tick();
    chk("wr_lo_ack_pulse", 64'(p_lo_ack), 64'd0);
    chk("wr_count", 64'(p_count), 64'(exp_cnt));
    chk("wr_core_rst", 64'(core_rst), 64'd1);
  endtask

  // Uncontended single read: data and ready one cycle after the request
  task automatic read_word(input int c, input logic [9:0] a, input logic [31:0] exp);
    active[c] = 1'b1;
    addr[c]   = a;
    tick();
    chk("rd_ready", 64'(ready), 64'(4'b0001 << c));
    chk("rd_data", 64'(d_out[c]), 64'(exp));
    active[c] = 1'b0;
    tick();
    chk("rd_ready_pulse", 64'(ready), 64'd0);
  endtask

  initial begin
    int   order [4];
    bit   seen;
    order   = '{1, 2, 3, 0};
    rst_n   = 1'b0;
    prog    = 1'b0;
    p_avail = 1'b0;
    p_d_in  = '0;
    active  = '0;
    addr    = '0;

    tick();
    tick();
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_p_ready", 64'(p_ready), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_count", 64'(p_count), 64'd0);
    chk("rst_full", 64'(p_full), 64'd0);
    chk("rst_d_out", 64'(d_out), 64'd0);

    rst_n = 1'b1;
    tick();
    chk("rel_core_rst", 64'(core_rst), 64'd0);

    prog = 1'b1;
    tick();
    chk("prog_core_rst", 64'(core_rst), 64'd1);
    write_word(W0, 11'd1);
    write_word(W1, 11'd2);
    write_word(W2, 11'd3);

    prog = 1'b0;
    chk("fall_core_rst_hold", 64'(core_rst), 64'd1);
    tick();
    chk("fall_core_rst_clear", 64'(core_rst), 64'd0);

    read_word(0, 10'd0, W0);
    read_word(0, 10'd1, W1);
    read_word(0, 10'd2, W2);

    // Different banks are served in the same cycle
    active  = 4'b0011;
    addr[0] = 10'd0;
    addr[1] = 10'd1;
    tick();
    chk("par_ready", 64'(ready), 64'b0011);
    chk("par_d0", 64'(d_out[0]), 64'(W0));
    chk("par_d1", 64'(d_out[1]), 64'(W1));
    active = '0;
    tick();

    // Bank 0 last granted core 0, so order is 1,2,3,0
    active = 4'b1111;
    for (int c = 0; c < 4; c++) addr[c] = 10'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_ready", 64'(ready), 64'(4'b0001 << order[k]));
      chk("rr_data", 64'(d_out[order[k]]), 64'(W2));
      active[order[k]] = 1'b0;
    end
    tick();
    chk("rr_done", 64'(ready), 64'd0);

    // Reset arriving with core 2's request drops it
    rst_n     = 1'b0;
    active[2] = 1'b1;
    addr[2]   = 10'd2;
    tick();
    chk("rstrd_ready", 64'(ready), 64'd0);
    chk("rstrd_d2", 64'(d_out[2]), 64'd0);
    chk("rstrd_count", 64'(p_count), 64'd0);
    rst_n  = 1'b1;
    active = '0;
    tick();
    chk("rstrd_core_rst", 64'(core_rst), 64'd0);
    read_word(2, 10'd2, W2);
    read_word(0, 10'd0, W0);

    // Fill the whole array in one session
    prog = 1'b1;
    tick();
    for (int i = 0; i < 1023; i++) write_word(32'hC000_0000 | 32'(i), 11'(i + 1));
    chk("fill_not_full", 64'(p_full), 64'd0);
    write_word(32'hC000_03FF, 11'd1024);
    chk("fill_full", 64'(p_full), 64'd1);
    chk("fill_count", 64'(p_count), 64'd1024);

    seen    = 1'b0;
    p_avail = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (p_ready) seen = 1'b1;
    end
    chk("full_no_ready", 64'(seen), 64'd0);
    p_avail = 1'b0;

    prog = 1'b0;
    tick();
    tick();
    prog = 1'b1;
    tick();
    chk("sess_count", 64'(p_count), 64'd0);
    chk("sess_full", 64'(p_full), 64'd0);
    write_word(32'h0BAD_F00D, 11'd1);
    prog = 1'b0;
    tick();
    tick();
    read_word(3, 10'd0, 32'h0BAD_F00D);
    read_word(1, 10'd1, 32'hC000_0001);
    read_word(0, 10'd1023, 32'hC000_03FF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
